dispatch_steer: RTL and testbench

// - Sits between rename/dispatch and the per-FU reservation stations (one scheduler instance per FU).
// - Steers each dispatched instruction to exactly one RS allowed by its FU mask, chosen round-robin.
// - Tracks free entries per RS with credit counters, so no RS is ever sent a packet while full.
// - Registers the packet to the chosen RS with 1-cycle latency and applies backpressure upstream.

---
 rtl/dispatch_steer_pkg.sv | 28 ++
 rtl/dispatch_steer_rr_arbiter.sv | 44 ++++
 rtl/dispatch_steer.sv | 126 ++++++++++++
 tb/tb_dispatch_steer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/dispatch_steer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dispatch_steer_pkg
// Brief    : Shared core types and sizing for dispatch and the RS slice.
// Revision : 1.0
// ============================================================================
package dispatch_steer_pkg;

  localparam int NUM_FUS     = 4;
  localparam int RS_ENTRIES  = 8;
  localparam int RS_CREDIT_W = $clog2(RS_ENTRIES + 1);

  typedef struct packed {
    logic [5:0]  rob_idx;
    logic [7:0]  opcode;
    logic [6:0]  dst_preg;
    logic [6:0]  src1_preg;
    logic [6:0]  src2_preg;
    logic [15:0] imm;
  } disp_packet_t;

  // Index width that stays legal when only one RS exists.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dispatch_steer_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick of the first request at/after ptr.
// Revision : 1.0
// ============================================================================
module rr_arbiter
  import dispatch_steer_pkg::*;
#(
  parameter int unsigned N  = 4,
  localparam int unsigned PW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant_onehot,
  output logic [PW-1:0] grant_idx,
  output logic          grant_valid
);

  int unsigned w_j;

  function automatic int unsigned wrap_idx(input logic [PW-1:0] base, input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    return (s >= N) ? s - N : s;
  endfunction

  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    grant_valid  = 1'b0;
    w_j          = 0;
    for (int unsigned i = 0; i < N; i++) begin
      w_j = wrap_idx(ptr, i);
      if (!grant_valid && req[w_j]) begin
        grant_valid  = 1'b1;
        grant_idx    = PW'(w_j);
        grant_onehot = N'(1) << w_j;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dispatch_steer.sv
`default_nettype none
// ============================================================================
// Module   : dispatch_steer
// Brief    : Credit-based round-robin steering of dispatch packets to RSs.
// Revision : 1.0
// ============================================================================
module dispatch_steer
  import dispatch_steer_pkg::*;
#(
  parameter  int NUM_RS   = NUM_FUS,
  parameter  int RS_DEPTH = RS_ENTRIES,
  localparam int CW       = $clog2(RS_DEPTH + 1),
  localparam int DW       = RS_DEPTH * NUM_RS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  disp_packet_t         in_pkt,
  input  logic [NUM_RS-1:0]    in_fu_mask,
  input  logic [DW-1:0]        in_dep_mask,
  output logic [NUM_RS-1:0]    out_valid,
  output disp_packet_t         out_pkt,
  output logic [DW-1:0]        out_dep_mask,
  input  logic [NUM_RS-1:0]    rs_issue,
  output logic [NUM_RS*CW-1:0] credits,
  output logic                 credit_err,
  output logic [31:0]          stall_cycles
);

  localparam int PW = idx_w(NUM_RS);
  localparam logic [CW-1:0] C_FULL = CW'(RS_DEPTH);

  logic [CW-1:0]     r_credit [NUM_RS];
  logic [PW-1:0]     r_rr_ptr;
  logic [NUM_RS-1:0] r_out_valid;
  disp_packet_t      r_out_pkt;
  logic [DW-1:0]     r_out_dep_mask;
  logic              r_credit_err;
  logic [31:0]       r_stall_cycles;

  logic [NUM_RS-1:0] w_elig;
  logic [NUM_RS-1:0] w_at_full;
  logic [NUM_RS-1:0] w_grant_onehot;
  logic [PW-1:0]     w_grant_idx;
  logic              w_grant_valid;
  logic              w_accept;
  logic [NUM_RS-1:0] w_dec;
  logic [NUM_RS-1:0] w_ovf;
  logic              w_bad_mask;
  logic              w_stall;
  logic [PW-1:0]     w_ptr_next;

  generate
    for (genvar k = 0; k < NUM_RS; k++) begin : g_rs
      assign w_elig[k]             = in_fu_mask[k] & (r_credit[k] != '0);
      assign w_at_full[k]          = (r_credit[k] == C_FULL);
      assign credits[k*CW +: CW]   = r_credit[k];
    end
  endgenerate

  rr_arbiter #(
    .N (NUM_RS)
  ) u_rr_arbiter (
    .req          (w_elig),
    .ptr          (r_rr_ptr),
    .grant_onehot (w_grant_onehot),
    .grant_idx    (w_grant_idx),
    .grant_valid  (w_grant_valid)
  );

  assign in_ready   = w_grant_valid & ~flush;
  assign w_accept   = in_valid & in_ready;
  assign w_dec      = w_accept ? w_grant_onehot : '0;
  // Issue landing on a full RS with no matching dispatch means the RS and we disagree.
  assign w_ovf      = rs_issue & ~w_dec & w_at_full;
  assign w_bad_mask = in_valid & (in_fu_mask == '0);
  assign w_stall    = in_valid & ~in_ready & ~flush;
  assign w_ptr_next = (w_grant_idx == PW'(NUM_RS - 1)) ? '0 : w_grant_idx + PW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid    <= '0;
      r_out_pkt      <= '0;
      r_out_dep_mask <= '0;
      r_rr_ptr       <= '0;
      r_credit_err   <= 1'b0;
      r_stall_cycles <= '0;
      for (int k = 0; k < NUM_RS; k++) begin
        r_credit[k] <= C_FULL;
      end
    end else begin
      r_out_valid <= flush ? '0 : w_dec;
      if (w_accept) begin
        r_out_pkt      <= in_pkt;
        r_out_dep_mask <= in_dep_mask;
        r_rr_ptr       <= w_ptr_next;
      end
      // Flushed RSs are empty, so every counter returns to full and issues are moot.
      for (int k = 0; k < NUM_RS; k++) begin
        if (flush) begin
          r_credit[k] <= C_FULL;
        end else if (w_dec[k] && !rs_issue[k]) begin
          r_credit[k] <= r_credit[k] - CW'(1);
        end else if (!w_dec[k] && rs_issue[k] && !w_at_full[k]) begin
          r_credit[k] <= r_credit[k] + CW'(1);
        end
      end
      if (((|w_ovf) && !flush) || w_bad_mask) begin
        r_credit_err <= 1'b1;
      end
      if (w_stall && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
    end
  end

  assign out_valid    = r_out_valid;
  assign out_pkt      = r_out_pkt;
  assign out_dep_mask = r_out_dep_mask;
  assign credit_err   = r_credit_err;
  assign stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_dispatch_steer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dispatch_steer
// Brief    : Directed self-checking bench for dispatch_steer (4 RS x 8 entries).
// Revision : 1.0
// ============================================================================
module tb_dispatch_steer;
  import dispatch_steer_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  disp_packet_t in_pkt = '0;
  logic [3:0]   in_fu_mask = '0;
  logic [31:0]  in_dep_mask = '0;
  logic [3:0]   out_valid;
  disp_packet_t out_pkt;
  logic [31:0]  out_dep_mask;
  logic [3:0]   rs_issue = '0;
  logic [15:0]  credits;
  logic         credit_err;
  logic [31:0]  stall_cycles;

  int n_checks = 0;
  int n_pass   = 0;

  dispatch_steer #(.NUM_RS(4), .RS_DEPTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pkt       (in_pkt),
    .in_fu_mask   (in_fu_mask),
    .in_dep_mask  (in_dep_mask),
    .out_valid    (out_valid),
    .out_pkt      (out_pkt),
    .out_dep_mask (out_dep_mask),
    .rs_issue     (rs_issue),
    .credits      (credits),
    .credit_err   (credit_err),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic disp_packet_t mkpkt(input int n);
    disp_packet_t p;
    p.rob_idx   = 6'(n);
    p.opcode    = 8'(n * 3 + 1);
    p.dst_preg  = 7'(n + 5);
    p.src1_preg = 7'(n + 9);
    p.src2_preg = 7'(n + 17);
    p.imm       = 16'(n * 257 + 16'h1234);
    return p;
  endfunction

  function automatic logic [31:0] mkdep(input int n);
    return 32'hC0DE_0000 | 32'(n);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int n);
    in_valid    = 1'b1;
    in_pkt      = mkpkt(n);
    in_dep_mask = mkdep(n);
  endtask

  // Pulses reset between clock edges, starting from edge+1.
  task automatic do_reset();
    in_valid = 1'b0; flush = 1'b0; rs_issue = '0; in_fu_mask = '0;
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    #2 rst = 1'b0;
    tick(); tick();
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_credits", 64'(credits), 64'h8888);
    check("rst_err", 64'(credit_err), 64'h0);
    check("rst_stall", 64'(stall_cycles), 64'h0);
    check("rst_pkt", 64'(out_pkt), 64'h0);
    rst = 1'b1;

    // Round-robin across all four RSs
    in_fu_mask = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      send(i);
      tick();
      check("rr_valid", 64'(out_valid), 64'(4'b0001 << i));
      check("rr_pkt", 64'(out_pkt), 64'(mkpkt(i)));
      check("rr_dep", 64'(out_dep_mask), 64'(mkdep(i)));
    end
    in_valid = 1'b0;
    check("rr_credits", 64'(credits), 64'h7777);
    tick();
    check("rr_idle", 64'(out_valid), 64'h0);

    // Fill RS0, stall, then release with one issue
    do_reset();
    in_fu_mask = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      send(10 + i);
      #1 check("fill_ready", 64'(in_ready), 64'h1);
      tick();
    end
    check("fill_credits", 64'(credits), 64'h8880);
    send(18);
    #1 check("fill_blocked", 64'(in_ready), 64'h0);
    repeat (5) tick();
    check("fill_stall5", 64'(stall_cycles), 64'd5);
    check("fill_no_out", 64'(out_valid), 64'h0);
    rs_issue = 4'b0001;
    tick();
    rs_issue = '0;
    check("fill_credit1", 64'(credits), 64'h8881);
    #1 check("fill_ready_again", 64'(in_ready), 64'h1);
    tick();
    in_valid = 1'b0;
    check("fill_valid", 64'(out_valid), 64'h1);
    check("fill_pkt", 64'(out_pkt), 64'(mkpkt(18)));
    check("fill_credit0", 64'(credits), 64'h8880);
    check("fill_stall6", 64'(stall_cycles), 64'd6);

    // Dispatch and issue to RS2 in the same cycle
    do_reset();
    in_fu_mask = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      send(20 + i);
      tick();
    end
    check("sim_credit3", 64'(credits), 64'h8388);
    send(25);
    rs_issue = 4'b0100;
    tick();
    in_valid = 1'b0;
    rs_issue = '0;
    check("sim_valid", 64'(out_valid), 64'h4);
    check("sim_pkt", 64'(out_pkt), 64'(mkpkt(25)));
    check("sim_credits", 64'(credits), 64'h8388);

    // Overflow on a full RS
    check("ovf_err_before", 64'(credit_err), 64'h0);
    rs_issue = 4'b0010;
    tick();
    rs_issue = '0;
    check("ovf_credits", 64'(credits), 64'h8388);
    check("ovf_err", 64'(credit_err), 64'h1);
    repeat (3) tick();
    check("ovf_sticky", 64'(credit_err), 64'h1);

    // Empty FU mask
    do_reset();
    check("bad_err_cleared", 64'(credit_err), 64'h0);
    in_fu_mask = 4'b0000;
    send(30);
    #1 check("bad_ready", 64'(in_ready), 64'h0);
    tick();
    in_valid = 1'b0;
    check("bad_err", 64'(credit_err), 64'h1);

    // Flush with a packet in the output register, credits {5,8,8,6}
    do_reset();
    in_fu_mask = 4'b1000;
    send(31); tick();
    send(32); tick();
    in_fu_mask = 4'b0001;
    send(33); tick();
    send(34); tick();
    send(35); tick();
    flush = 1'b1;
    rs_issue = 4'b0010;
    in_fu_mask = 4'b1111;
    send(40);
    #1 check("fl_ready", 64'(in_ready), 64'h0);
    check("fl_inflight", 64'(out_valid), 64'h1);
    check("fl_credits_pre", 64'(credits), 64'h6885);
    tick();
    flush = 1'b0;
    rs_issue = '0;
    check("fl_dropped", 64'(out_valid), 64'h0);
    check("fl_credits", 64'(credits), 64'h8888);
    check("fl_stall", 64'(stall_cycles), 64'h0);
    tick();
    check("fl_rr_rs1", 64'(out_valid), 64'h2);
    check("fl_pkt", 64'(out_pkt), 64'(mkpkt(40)));
    send(41);
    tick();
    check("fl_rr_rs2", 64'(out_valid), 64'h4);

    // Async reset with a packet in flight
    send(42);
    tick();
    in_valid = 1'b0;
    check("ar_valid", 64'(out_valid), 64'h8);
    check("ar_pkt", 64'(out_pkt), 64'(mkpkt(42)));
    #2 rst = 1'b0;
    #1;
    check("ar_cleared", 64'(out_valid), 64'h0);
    check("ar_credits", 64'(credits), 64'h8888);
    check("ar_pkt_zero", 64'(out_pkt), 64'h0);
    #1 rst = 1'b1;
    send(43);
    tick();
    in_valid = 1'b0;
    check("ar_ptr_reset", 64'(out_valid), 64'h1);
    check("ar_pkt_after", 64'(out_pkt), 64'(mkpkt(43)));
    tick();
    check("ar_single_pulse", 64'(out_valid), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
